encode_packet_mlane: RTL and testbench

//  Multi-lane DFX frame packetiser for the 4-lane router TX path. Captures one

---
 rtl/encode_packet_mlane.sv | 209 ++++++++++++++++++++
 tb/tb_encode_packet_mlane.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_packet_mlane.sv
// ---------------------------------------------------------------------------
// encode_packet_mlane
//   Multi-lane DFX frame packetiser for the router TX path. A frame accepted
//   in IDLE is sliced into NUM_PKT words of {payload, ttl, seq, src}. The
//   words are striped round-robin over the enabled lanes. Every lane has a
//   one-deep output register with valid/ready handshaking.
//
// Ports
//   clk               clock
//   rst_n             asynchronous active-low reset
//   start_encode_pkt  frame request (accepted when ready_encode_pkt=1 in IDLE)
//   data_dfx_send     frame, sampled on accept
//   cfg_ttl/cfg_src   header fields, sampled on accept
//   cfg_lane_en       lane enable mask, sampled on accept (0 means lane 0 only)
//   ready_encode_pkt  registered idle/accept indication
//   encode_done       one-cycle pulse once every word has left its lane
//   lane_valid        per-lane word valid
//   lane_ready        per-lane sink ready
//   lane_data         lane l word at [l*AURORA_DATA_WIDTH +: AURORA_DATA_WIDTH]
// ---------------------------------------------------------------------------
module encode_packet_mlane #(
    parameter int DATA_DFX_WIDTH    = 1034,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int NUM_LANES         = 4,
    parameter int TTL_WIDTH         = 2,
    parameter int SEQ_WIDTH         = 5,
    parameter int SRC_WIDTH         = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start_encode_pkt,
    input  logic [DATA_DFX_WIDTH-1:0]              data_dfx_send,
    input  logic [TTL_WIDTH-1:0]                   cfg_ttl,
    input  logic [SRC_WIDTH-1:0]                   cfg_src,
    input  logic [NUM_LANES-1:0]                   cfg_lane_en,
    output logic                                   ready_encode_pkt,
    output logic                                   encode_done,
    output logic [NUM_LANES-1:0]                   lane_valid,
    input  logic [NUM_LANES-1:0]                   lane_ready,
    output logic [NUM_LANES*AURORA_DATA_WIDTH-1:0] lane_data
);

    localparam int PAYLOAD_W = AURORA_DATA_WIDTH - TTL_WIDTH - SEQ_WIDTH - SRC_WIDTH;
    localparam int NUM_PKT   = (DATA_DFX_WIDTH + PAYLOAD_W - 1) / PAYLOAD_W;
    localparam int FRAME_W   = NUM_PKT * PAYLOAD_W;
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [SEQ_WIDTH-1:0] LAST_K = SEQ_WIDTH'(NUM_PKT - 1);

    // Elaboration-time sanity checks on the parameter set.
    if ((2 ** SEQ_WIDTH) < NUM_PKT) begin : g_seq_too_narrow
        $error("encode_packet_mlane: SEQ_WIDTH too small for NUM_PKT");
    end
    if ((NUM_LANES < 1) || (NUM_LANES > 8)) begin : g_lanes_out_of_range
        $error("encode_packet_mlane: NUM_LANES must be 1..8");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENCODE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_ready;
    logic [FRAME_W-1:0]      r_frame;
    logic [TTL_WIDTH-1:0]    r_ttl;
    logic [SRC_WIDTH-1:0]    r_src;
    logic [NUM_LANES-1:0]    r_mask;
    logic [SEQ_WIDTH-1:0]    r_k;
    logic [LANE_W-1:0]       r_lane;

    logic                    w_accept;
    logic                    w_load;
    logic                    w_target_free;
    logic [NUM_LANES-1:0]    w_mask_in;
    logic [NUM_LANES-1:0]    w_lane_valid;
    logic [AURORA_DATA_WIDTH-1:0] w_word;

    // Next enabled lane strictly above 'cur', wrapping around. Called with
    // cur = NUM_LANES-1 it yields the lowest enabled lane.
    function automatic logic [LANE_W-1:0] f_next_lane(
        input logic [NUM_LANES-1:0] mask,
        input logic [LANE_W-1:0]    cur
    );
        logic [LANE_W-1:0] res;
        logic [LANE_W-1:0] li;
        logic              found;
        int                idx;
        res   = cur;
        found = 1'b0;
        for (int o = 1; o <= NUM_LANES; o++) begin
            idx = (int'(cur) + o) % NUM_LANES;
            li  = LANE_W'(idx);
            if (!found && mask[li]) begin
                res   = li;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_mask_in     = (cfg_lane_en == '0) ? NUM_LANES'(1) : cfg_lane_en;
    assign w_accept      = start_encode_pkt & r_ready & (r_state == S_IDLE);
    assign w_target_free = !w_lane_valid[r_lane] | lane_ready[r_lane];

    // The frame register shifts down one payload per load, so the current
    // word's payload is always the bottom slice. Bits beyond the frame width
    // were zero-filled on capture, which pads the last word.
    assign w_word = {r_frame[PAYLOAD_W-1:0], r_ttl, r_k, r_src};

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_ENCODE;
                end
            end
            S_ENCODE: begin
                if (w_target_free) begin
                    w_load = 1'b1;
                    if (r_k == LAST_K) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_lane_valid == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------- Frame / control datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_frame <= '0;
            r_ttl   <= '0;
            r_src   <= '0;
            r_mask  <= '0;
            r_k     <= '0;
            r_lane  <= '0;
        end else begin
            // Rises one edge after entering IDLE, drops the edge after accept.
            r_ready <= (r_state == S_IDLE) && !w_accept;
            if (w_accept) begin
                r_frame <= FRAME_W'(data_dfx_send);
                r_ttl   <= cfg_ttl;
                r_src   <= cfg_src;
                r_mask  <= w_mask_in;
                r_k     <= '0;
                r_lane  <= f_next_lane(w_mask_in, LANE_W'(NUM_LANES - 1));
            end else if (w_load) begin
                r_frame <= r_frame >> PAYLOAD_W;
                r_k     <= r_k + 1'b1;
                r_lane  <= f_next_lane(r_mask, r_lane);
            end
        end
    end

    // ---------------- Per-lane output registers ----------------
    genvar gi;
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic                         r_valid;
        logic [AURORA_DATA_WIDTH-1:0] r_data;

        // A load may land in the same cycle as a transfer; the load wins so
        // the lane keeps streaming at one word per clock.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_load && (r_lane == LANE_W'(gi))) begin
                r_valid <= 1'b1;
                r_data  <= w_word;
            end else if (lane_ready[gi]) begin
                r_valid <= 1'b0;
            end
        end

        assign w_lane_valid[gi] = r_valid;
        assign lane_data[gi*AURORA_DATA_WIDTH +: AURORA_DATA_WIDTH] = r_data;
    end

    assign lane_valid       = w_lane_valid;
    assign ready_encode_pkt = r_ready;
    assign encode_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_encode_packet_mlane.sv
// ---------------------------------------------------------------------------
// tb_encode_packet_mlane
//   Directed/randomised bench for encode_packet_mlane. A scoreboard builds the
//   expected per-lane word streams from each accepted frame (payload slices,
//   header fields, round-robin over the enabled-lane list) and a monitor
//   checks every lane transfer, hold stability, disabled lanes, ready/done
//   timing and the word count per frame.
// ---------------------------------------------------------------------------
module tb_encode_packet_mlane;

    localparam int DW = 1034;
    localparam int AW = 64;
    localparam int NL = 4;
    localparam int PW = 55;
    localparam int NP = 19;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [DW-1:0]   data;
    logic [1:0]      ttl;
    logic [1:0]      src;
    logic [NL-1:0]   lane_en;
    logic [NL-1:0]   lane_ready;
    logic            ready;
    logic            done;
    logic [NL-1:0]   lane_valid;
    logic [NL*AW-1:0] lane_data;

    always #5 clk = ~clk;

    encode_packet_mlane #(
        .DATA_DFX_WIDTH(DW), .AURORA_DATA_WIDTH(AW), .NUM_LANES(NL),
        .TTL_WIDTH(2), .SEQ_WIDTH(5), .SRC_WIDTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_encode_pkt(start),
        .data_dfx_send(data), .cfg_ttl(ttl), .cfg_src(src),
        .cfg_lane_en(lane_en), .ready_encode_pkt(ready),
        .encode_done(done), .lane_valid(lane_valid),
        .lane_ready(lane_ready), .lane_data(lane_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- Scoreboard ----------------
    logic [63:0]   exp_mem [NL][512];
    int            head [NL];
    int            tail [NL];
    logic [NL-1:0] cur_mask = '0;
    int            words_rx = 0;
    int            done_cnt = 0;
    int            acc_cnt  = 0;

    task automatic push_frame(input logic [DW-1:0] f, input logic [1:0] t,
                              input logic [1:0] s, input logic [NL-1:0] en);
        logic [NP*PW-1:0] fp;
        int lanes[$];
        int l;
        fp = '0;
        fp[DW-1:0] = f;
        for (int i = 0; i < NL; i++) if (en[i]) lanes.push_back(i);
        if (lanes.size() == 0) lanes.push_back(0);
        for (int k = 0; k < NP; k++) begin
            l = lanes[k % lanes.size()];
            exp_mem[l][tail[l]] = {fp[k*PW +: PW], t, 5'(k), s};
            tail[l]++;
        end
        cur_mask = (en == '0) ? 4'b0001 : en;
    endtask

    // ---------------- Monitor ----------------
    initial begin
        logic [NL-1:0]    prev_v, prev_r;
        logic [NL*AW-1:0] prev_d;
        logic             prev_acc, prev_done, all_empty;
        int               since_done;
        logic [63:0]      w;
        prev_v = '0; prev_r = '0; prev_d = '0; prev_acc = 0; prev_done = 0;
        since_done = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = '0; prev_acc = 0; prev_done = 0; since_done = -1;
                continue;
            end
            for (int l = 0; l < NL; l++) begin
                if (prev_v[l] && !prev_r[l]) begin
                    chk("hold_valid", lane_valid[l], 1'b1);
                    chk("hold_data", lane_data[l*AW +: AW], prev_d[l*AW +: AW]);
                end
                if (!cur_mask[l]) chk("disabled_lane_valid", lane_valid[l], 1'b0);
            end
            if (prev_acc) chk("ready_low_after_accept", ready, 1'b0);
            if (since_done >= 0) since_done++;
            if (since_done == 1) chk("ready_cycle1_after_done", ready, 1'b0);
            if (since_done == 2) begin
                chk("ready_cycle2_after_done", ready, 1'b1);
                since_done = -1;
            end
            for (int l = 0; l < NL; l++) begin
                if (lane_valid[l] && lane_ready[l]) begin
                    w = lane_data[l*AW +: AW];
                    chk("word_expected_on_lane", head[l] < tail[l], 1'b1);
                    if (head[l] < tail[l]) begin
                        chk($sformatf("lane%0d_word", l), w, exp_mem[l][head[l]]);
                        head[l]++;
                    end
                    if (w[6:2] == 5'd18) chk("last_word_pad", w[63:53], 11'd0);
                    $display("lane%0d xfer word=%016h seq=%0d", l, w, w[6:2]);
                    words_rx++;
                end
            end
            if (done) begin
                all_empty = 1'b1;
                for (int l = 0; l < NL; l++) if (head[l] != tail[l]) all_empty = 1'b0;
                chk("words_per_frame", words_rx, NP);
                chk("scoreboard_empty_at_done", all_empty, 1'b1);
                chk("done_one_cycle", prev_done, 1'b0);
                $display("frame done #%0d words=%0d", done_cnt + 1, words_rx);
                done_cnt++;
                since_done = 0;
            end
            prev_acc = start && ready;
            if (prev_acc) begin
                push_frame(data, ttl, src, lane_en);
                words_rx = 0;
                acc_cnt++;
                $display("accept frame mask=%b ttl=%0d src=%0d", lane_en, ttl, src);
            end
            prev_v = lane_valid; prev_r = lane_ready; prev_d = lane_data;
            prev_done = done;
        end
    end

    // ---------------- Stimulus helpers ----------------
    function automatic logic [DW-1:0] rand_frame();
        logic [DW-1:0] f;
        for (int i = 0; i < DW; i++) f[i] = 1'($urandom_range(0, 1));
        return f;
    endfunction

    task automatic send_frame(input logic [DW-1:0] f, input logic [1:0] t,
                              input logic [1:0] s, input logic [NL-1:0] en);
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_send", ready, 1'b1);
        data = f; ttl = t; src = s; lane_en = en; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, input bit rnd_ready);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < lim) begin
            if (rnd_ready) lane_ready = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            n++;
        end
        chk("done_within_budget", done_cnt != d0, 1'b1);
        lane_ready = '1;
    endtask

    // ---------------- Directed sequence ----------------
    initial begin
        logic [DW-1:0] f;
        logic [7:0]    bv;
        int            d0, a0, n;

        for (int l = 0; l < NL; l++) begin head[l] = 0; tail[l] = 0; end
        rst_n = 1'b0; start = 1'b0; data = '0; ttl = '0; src = '0;
        lane_en = '0; lane_ready = '1;
        #2;
        chk("reset_ready", ready, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_lane_valid", lane_valid, 4'd0);
        chk("reset_lane_data", lane_data, 256'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", ready, 1'b1);

        // 1: incrementing bytes, all lanes, ttl=2 src=0
        for (int i = 0; i < DW; i++) begin
            bv = 8'(i / 8);
            f[i] = bv[i % 8];
        end
        send_frame(f, 2'd2, 2'd0, 4'b1111);
        wait_done(200, 0);

        // 2: lanes 0 and 2
        send_frame(rand_frame(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'b0101);
        wait_done(200, 0);

        // 3: empty mask -> lane 0 only
        send_frame(rand_frame(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'b0000);
        wait_done(200, 0);

        // 4: lane 1 stalled for 10 cycles mid-frame
        send_frame(rand_frame(), 2'd1, 2'd3, 4'b1111);
        repeat (3) @(posedge clk);
        #1 lane_ready = 4'b1101;
        repeat (10) @(posedge clk);
        #1 lane_ready = 4'b1111;
        wait_done(200, 0);

        // 4b: random backpressure on three lanes
        send_frame(rand_frame(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'b1011);
        wait_done(400, 1);

        // 5: start held high, two frames back-to-back
        d0 = done_cnt; a0 = acc_cnt; n = 0;
        while (!ready && n < 100) begin @(posedge clk); #1; n++; end
        data = rand_frame(); ttl = 2'd3; src = 2'd1; lane_en = 4'b0110; start = 1'b1;
        @(posedge clk); #1;
        data = rand_frame(); ttl = 2'd0; src = 2'd2; lane_en = 4'b1001;
        n = 0;
        while (done_cnt < d0 + 2 && n < 400) begin @(posedge clk); #1; n++; end
        start = 1'b0;
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("b2b_accept_count", acc_cnt - a0, 2);

        // 6: reset in the middle of a frame
        send_frame(rand_frame(), 2'd2, 2'd1, 4'b1111);
        n = 0;
        while (words_rx < 7 && n < 100) begin @(posedge clk); #1; n++; end
        chk("reached_word7", words_rx >= 7, 1'b1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", ready, 1'b0);
        chk("midreset_done", done, 1'b0);
        chk("midreset_lane_valid", lane_valid, 4'd0);
        chk("midreset_lane_data", lane_data, 256'd0);
        for (int l = 0; l < NL; l++) begin head[l] = 0; tail[l] = 0; end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_midreset", done_cnt, d0);
        send_frame(rand_frame(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'b1111);
        wait_done(200, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
